// File: rtl/barrel_shift_scheduler_if.sv
// Handshake and shifter-facing bus of the barrel shift scheduler.
// The master modport is the scheduler's view; slave is the source/shifter side.
interface barrel_shift_scheduler_if #(
    parameter int WORD_SIZE  = 256,
    parameter int NOF_PES    = 16,
    parameter int NOF_LEVELS = $clog2(NOF_PES)
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WORD_SIZE*NOF_PES-1:0]  in_data;
    logic [NOF_PES-1:0]            in_phase_mask;
    logic [WORD_SIZE*NOF_PES-1:0]  sh_data;
    logic [NOF_LEVELS-1:0]         sh_amt;
    logic                          out_valid;
    logic                          out_ready;
    logic [NOF_LEVELS-1:0]         out_phase;
    logic                          out_last;

    modport master (
        input  in_valid, in_data, in_phase_mask, out_ready,
        output in_ready, sh_data, sh_amt, out_valid, out_phase, out_last
    );

    modport slave (
        output in_valid, in_data, in_phase_mask, out_ready,
        input  in_ready, sh_data, sh_amt, out_valid, out_phase, out_last
    );
endinterface

// File: rtl/barrel_shift_scheduler.sv
// Holds one frame and steps the rotation amount through the phases enabled
// by the per-frame mask, in ascending order, under valid/ready flow control.
module barrel_shift_scheduler #(
    parameter int WORD_SIZE  = 256,
    parameter int NOF_PES    = 16,
    parameter int NOF_LEVELS = $clog2(NOF_PES)
) (
    input  logic                        clk,
    input  logic                        rst,
    barrel_shift_scheduler_if.master    bus,
    output logic                        busy,
    output logic [15:0]                 frame_cnt
);

    localparam int FRAME_W = WORD_SIZE * NOF_PES;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_n;
    logic [FRAME_W-1:0]     data_q, data_n;
    logic [NOF_PES-1:0]     mask_q, mask_n;
    logic [NOF_LEVELS-1:0]  amt_q, amt_n;
    logic                   last_q, last_n;
    logic [15:0]            cnt_q, cnt_n;

    logic                   fire;
    logic                   accept;
    logic [NOF_LEVELS-1:0]  next_idx;
    logic                   next_last;
    logic [NOF_LEVELS-1:0]  first_idx;
    logic                   first_last;

    // Lowest set mask bit at or above start; callers guarantee one exists.
    function automatic logic [NOF_LEVELS-1:0] lowest_from(
        input logic [NOF_PES-1:0] m,
        input int                 start
    );
        logic [NOF_LEVELS-1:0] idx;
        idx = '0;
        for (int i = NOF_PES - 1; i >= 0; i--) begin
            if (i >= start && m[i]) begin
                idx = NOF_LEVELS'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic none_above(
        input logic [NOF_PES-1:0]    m,
        input logic [NOF_LEVELS-1:0] idx
    );
        logic found;
        found = 1'b0;
        for (int i = 0; i < NOF_PES; i++) begin
            if (i > int'(idx) && m[i]) begin
                found = 1'b1;
            end
        end
        return !found;
    endfunction

    assign fire       = (state_q == RUN) && bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) || (fire && last_q);
    assign accept     = bus.in_valid && bus.in_ready;

    assign next_idx   = lowest_from(mask_q, int'(amt_q) + 1);
    assign next_last  = none_above(mask_q, next_idx);
    assign first_idx  = lowest_from(bus.in_phase_mask, 0);
    assign first_last = none_above(bus.in_phase_mask, first_idx);

    // Completion and a zero-mask drop in the same cycle both count as frames.
    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        mask_n  = mask_q;
        amt_n   = amt_q;
        last_n  = last_q;
        cnt_n   = cnt_q;

        if (fire && last_q) begin
            state_n = IDLE;
            last_n  = 1'b0;
            cnt_n   = cnt_n + 16'd1;
        end else if (fire) begin
            amt_n  = next_idx;
            last_n = next_last;
        end

        if (accept) begin
            data_n = bus.in_data;
            mask_n = bus.in_phase_mask;
            if (bus.in_phase_mask != '0) begin
                state_n = RUN;
                amt_n   = first_idx;
                last_n  = first_last;
            end else begin
                state_n = IDLE;
                last_n  = 1'b0;
                cnt_n   = cnt_n + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            amt_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            mask_q  <= mask_n;
            amt_q   <= amt_n;
            last_q  <= last_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.out_valid = (state_q == RUN);
    assign bus.sh_data   = data_q;
    assign bus.sh_amt    = amt_q;
    assign bus.out_phase = amt_q;
    assign bus.out_last  = last_q;
    assign busy          = (state_q == RUN);
    assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_barrel_shift_scheduler.sv
// Directed and random checks of barrel_shift_scheduler (NOF_PES=4, WORD_SIZE=8)
// against a phase scoreboard filled at accept time and drained on handshakes.
module tb_barrel_shift_scheduler;

    localparam int WS = 8;
    localparam int NP = 4;
    localparam int NL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    barrel_shift_scheduler_if #(.WORD_SIZE(WS), .NOF_PES(NP)) bus ();

    barrel_shift_scheduler #(.WORD_SIZE(WS), .NOF_PES(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [31:0]   data;
        logic [NL-1:0] amt;
        logic          last;
    } phase_t;

    phase_t      sb[$];
    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [15:0] exp_cnt = '0;
    logic [31:0] exp_data = '0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_frame(input logic [31:0] d, input logic [NP-1:0] m);
        phase_t p;
        for (int k = 0; k < NP; k++) begin
            if (m[k]) begin
                p.data = d;
                p.amt  = NL'(k);
                p.last = ((m >> (k + 1)) == '0);
                sb.push_back(p);
            end
        end
    endtask

    // Drives one cycle at the negedge, checks outputs against the model, then
    // advances the model by what the coming posedge should do.
    task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                  input logic [NP-1:0] m, input logic rdy);
        logic has;
        logic exp_ready;
        bus.in_valid      = v;
        bus.in_data       = d;
        bus.in_phase_mask = m;
        bus.out_ready     = rdy;
        #1;
        has       = (sb.size() != 0);
        exp_ready = !has;
        if (has && rdy && sb[0].last) exp_ready = 1'b1;
        check_output("out_valid", 32'(bus.out_valid), 32'(has));
        check_output("busy", 32'(busy), 32'(has));
        check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check_output("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check_output("sh_data", bus.sh_data, exp_data);
        if (has && bus.out_valid) begin
            check_output("sh_amt", 32'(bus.sh_amt), 32'(sb[0].amt));
            check_output("out_phase", 32'(bus.out_phase), 32'(sb[0].amt));
            check_output("out_last", 32'(bus.out_last), 32'(sb[0].last));
        end
        if (has && rdy) begin
            if (sb[0].last) exp_cnt = exp_cnt + 16'd1;
            void'(sb.pop_front());
        end
        if (v && exp_ready) begin
            exp_data = d;
            if (m == '0) exp_cnt = exp_cnt + 16'd1;
            else push_frame(d, m);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_phase_mask = '0;
        bus.out_ready     = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt  = '0;
        exp_data = '0;
        #1;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_sh_amt", 32'(bus.sh_amt), 32'd0);
        check_output("rst_out_phase", 32'(bus.out_phase), 32'd0);
        check_output("rst_out_last", 32'(bus.out_last), 32'd0);
        check_output("rst_sh_data", bus.sh_data, 32'd0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            apply_stimulus(1'b0, 32'd0, 4'b0000, 1'b1);
            budget++;
        end
        if (sb.size() != 0) begin
            n_vectors++;
            n_miscompares++;
            $display("[TB] FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        apply_stimulus(1'b0, 32'd0, 4'b0000, 1'b1);
    endtask

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_phase_mask = '0;
        bus.out_ready     = 1'b0;

        do_reset();

        // Full mask: phases 0..3 back to back.
        apply_stimulus(1'b1, 32'h44332211, 4'b1111, 1'b1);
        drain();
        check_output("cnt_after_full", 32'(frame_cnt), 32'd1);

        // Sparse mask: only phases 1 and 3.
        apply_stimulus(1'b1, 32'h44332211, 4'b1010, 1'b1);
        drain();

        // Single phase stalled by the downstream for five cycles.
        apply_stimulus(1'b1, 32'h44332211, 4'b0100, 1'b0);
        repeat (5) apply_stimulus(1'b0, 32'd0, 4'b0000, 1'b0);
        drain();

        // Second frame offered throughout the first; taken on its last phase.
        apply_stimulus(1'b1, 32'h44332211, 4'b1111, 1'b1);
        repeat (4) apply_stimulus(1'b1, 32'hDDCCBBAA, 4'b0001, 1'b1);
        drain();
        check_output("cnt_after_b2b", 32'(frame_cnt), 32'd5);

        // Zero mask is dropped but still counted.
        apply_stimulus(1'b1, 32'h12345678, 4'b0000, 1'b1);
        repeat (3) apply_stimulus(1'b0, 32'd0, 4'b0000, 1'b1);
        check_output("cnt_after_drop", 32'(frame_cnt), 32'd6);

        // Reset while phase 1 of a full-mask frame is presented.
        apply_stimulus(1'b1, 32'h44332211, 4'b1111, 1'b1);
        apply_stimulus(1'b0, 32'd0, 4'b0000, 1'b1);
        do_reset();

        // Random traffic with random backpressure.
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), $urandom,
                           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/barrel_shift_scheduler.md
Name: barrel_shift_scheduler

Overview:
Sequences a cyclic rotation exchange across NOF_PES processing elements. Accepts one frame of NOF_PES words through a valid/ready handshake and holds it in a frame register. Steps the rotation amount through the phases enabled by a per-frame phase mask, presenting the held frame plus the current shift amount to a downstream barrel shifter. Sits between the PE word collectors and the shifter datapath, replacing a free-running rotation counter with a flow-controlled, maskable schedule.

Parameters:
WORD_SIZE, 256, width of one PE word in bits
NOF_PES, 16, number of PEs / words per frame; power of two, >= 2
NOF_LEVELS, $clog2(NOF_PES), width of shift amount and phase index

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  frame offered
in_ready  output  1  scheduler can accept a frame this cycle
in_data  input  WORD_SIZE*NOF_PES  frame; word p at bits [p*WORD_SIZE +: WORD_SIZE]
in_phase_mask  input  NOF_PES  bit k set = issue rotation phase k for this frame
sh_data  output  WORD_SIZE*NOF_PES  held frame driven to the shifter
sh_amt  output  NOF_LEVELS  rotation amount in words for the current phase
out_valid  output  1  current phase valid
out_ready  input  1  downstream consumed current phase
out_phase  output  NOF_LEVELS  index of current phase (equals sh_amt)
out_last  output  1  current phase is the last enabled phase of the frame
busy  output  1  a frame is held (state RUN)
frame_cnt  output  16  number of frames completed or dropped since reset, wraps at 2^16

Behaviour:
- Reset (rst=1 at posedge): state IDLE; out_valid=0, out_last=0, busy=0, sh_amt=0, out_phase=0, sh_data=0, frame_cnt=0, stored mask=0. rst overrides all other inputs, including mid-frame; the held frame is discarded with no further out_valid.
- States: IDLE, RUN.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). Combinational; depends on out_ready only in the last-phase case.
- Accept: in_valid & in_ready at posedge. The frame is latched into sh_data and the mask is stored.
  - Mask nonzero: enter RUN with sh_amt = lowest set mask bit; out_valid=1 from the next cycle.
  - Mask zero: frame dropped, frame_cnt+1, state IDLE, out_valid=0.
- Latency: accept edge to first out_valid = 1 cycle; no bubble between phases.
- RUN: out_valid=1; sh_data, sh_amt, out_phase and out_last are held stable while out_ready=0.
  - On out_valid & out_ready with out_last=0: sh_amt advances to the next set mask bit strictly above the current index. Skipped phases consume no cycles.
  - out_last = no set mask bit above the current index (registered with sh_amt).
  - On out_valid & out_ready & out_last: frame_cnt+1. If an accept occurs in the same cycle, load the new frame and apply the accept rules. Otherwise go to IDLE, out_valid=0, out_last=0.
- sh_data persists after completion until the next accept or reset. sh_amt/out_phase keep their last value in IDLE.
- in_valid while in_ready=0 is ignored; the source must hold it. No in_data/mask is sampled outside accept cycles.
- Phase ordering is always ascending index. Phase 0 means identity rotation.
- Shifter contract: lane p of the shifter output = word (p+sh_amt) mod NOF_PES of sh_data.
- frame_cnt wraps from 0xFFFF to 0.

Test Plan:
- NOF_PES=4, WORD_SIZE=8. Reset, then in_data=0x44332211, mask=4'b1111, out_ready=1 -> out_valid on 4 consecutive cycles with sh_amt 0,1,2,3; out_last only on phase 3; frame_cnt=1; busy drops next cycle.
- Mask=4'b1010, out_ready=1 -> exactly 2 phases, sh_amt=1 then 3 (out_last=1 on 3); sh_data=0x44332211 throughout.
- Mask=4'b0100 with out_ready held 0 for 5 cycles -> out_valid, sh_amt=2, out_last=1 stable all 5 cycles; in_ready=0; completes on the first cycle out_ready=1.
- Back-to-back: second frame 0xDDCCBBAA, mask 4'b0001, offered during the last phase of frame 1 -> accepted on the same edge as the last handshake; next cycle sh_data=0xDDCCBBAA, sh_amt=0, out_last=1, no idle cycle; frame_cnt=2 after it completes.
- Mask=4'b0000 accepted -> no out_valid ever, frame_cnt increments by 1, in_ready stays 1.
- rst asserted during phase 1 of a 4'b1111 frame -> next cycle out_valid=0, busy=0, sh_amt=0, sh_data=0, frame_cnt=0, in_ready=1.
